// File: rtl/seq_det_param.sv
// seq_det_param -- parameterised Mealy serial-pattern detector.
//
// Compares the last SEQ_LEN accepted bits (history + current x) against a
// run-time loaded pattern and raises z in the same cycle as the final bit.
// Overlapping or non-overlapping detection is selected per cycle by overlap.
//
// Build option: define MATCH_CNT_EN to add a saturating match counter
// (match_cnt, CNT_W bits). Without it the port and counter do not exist and
// CNT_W is ignored; z behaves identically either way.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   x         serial data bit
//   x_vld     x is accepted only when high
//   pat_load  one-cycle strobe: latch pat_in, flush history (wins over x_vld)
//   pat_in    pattern, MSB is the first bit received
//   overlap   1 = overlapping matches, 0 = restart after each match
//   z         combinational match flag
//   match_cnt saturating count of z pulses (MATCH_CNT_EN only)
module seq_det_param #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_vld,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pat_in,
  input  logic               overlap,
`ifdef MATCH_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               z
);

  // fill counts 0..SEQ_LEN-1; a 1-bit counter is enough for SEQ_LEN=2.
  localparam int FILL_W = (SEQ_LEN <= 2) ? 1 : $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-2:0] hist;
  logic [SEQ_LEN-2:0] hist_sh;
  logic [FILL_W-1:0]  fill;
  logic [SEQ_LEN-1:0] pat;
  logic               accept;

  assign accept = x_vld & ~pat_load;

  // With SEQ_LEN=2 the history is a single bit, so the shift is just a load.
  generate
    if (SEQ_LEN == 2) begin : g_hist1
      assign hist_sh = x;
    end else begin : g_histn
      assign hist_sh = {hist[SEQ_LEN-3:0], x};
    end
  endgenerate

  // A match needs a full window of history plus the current bit.
  assign z = accept & (fill == FILL_MAX) & ({hist, x} == pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      pat  <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (x_vld) begin
      if (z && !overlap) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_sh;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

`ifdef MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         match_cnt <= '0;
    else if (pat_load)               match_cnt <= '0;
    else if (z && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule
